// File: rtl/lns_pkg.sv
// Shared LNS constants and sequencer state encoding for the dot-product sequencer.
package lns_pkg;

    localparam logic [15:0] LNS_ZERO = 16'h4000;
    localparam logic [15:0] LNS_ONE  = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_DRAIN,
        ST_MERGE,
        ST_WAIT0,
        ST_WAIT1,
        ST_DONE
    } lns_state_e;

endpackage

// File: rtl/lns_dot_seq_if.sv
// Bundle of control, operand, lnspipe and status signals of lns_dot_seq.
// Optional stall_cnt signal exists only when LNS_DOT_STALL_CNT_EN is defined.
interface lns_dot_seq_if #(parameter int LEN_W = 8);
    import lns_pkg::*;

    logic             start;
    logic [LEN_W-1:0] len;
    // Operand handshake: a pair moves on a rising edge where opd_valid & opd_ready;
    // opd_ready never depends on opd_valid, and the source holds data while valid is low-ready.
    logic             opd_valid;
    logic             opd_ready;
    logic [15:0]      opd_b;
    logic [15:0]      opd_c;
    logic [15:0]      alua0;
    logic [15:0]      alub0;
    logic [15:0]      aluc0;
    logic [15:0]      alur2;
    logic             busy;
    logic             done;
    logic [15:0]      result;
    lns_state_e       dbg_state;
`ifdef LNS_DOT_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    modport master (
        output start, len, opd_valid, opd_b, opd_c, alur2,
        input  opd_ready, alua0, alub0, aluc0, busy, done, result,
`ifdef LNS_DOT_STALL_CNT_EN
        input  stall_cnt,
`endif
        input  dbg_state
    );

    modport slave (
        input  start, len, opd_valid, opd_b, opd_c, alur2,
        output opd_ready, alua0, alub0, aluc0, busy, done, result,
`ifdef LNS_DOT_STALL_CNT_EN
        output stall_cnt,
`endif
        output dbg_state
    );

endinterface

// File: rtl/lns_dot_seq.sv
// Dot-product sequencer feeding an external 2-cycle lnspipe with two interleaved partial sums.
// Define LNS_DOT_STALL_CNT_EN to add the stall_cnt bubble counter.
module lns_dot_seq #(
    parameter int LEN_W = 8
) (
    input  logic          sysclk,
    input  logic          reset,
    lns_dot_seq_if.slave  bus
);
    import lns_pkg::*;

    lns_state_e       r_state;
    logic [LEN_W-1:0] r_rem;
    logic [1:0]       r_acc_cnt;
    logic [15:0]      r_hold;
    logic [15:0]      r_result;

    logic             w_ready;
    logic             w_xfer;
    logic [LEN_W-1:0] w_rem_next;
    logic [15:0]      w_alua;
    logic [15:0]      w_alub;
    logic [15:0]      w_aluc;

    assign w_ready    = (r_state == ST_ACC) && (r_rem != '0);
    assign w_xfer     = bus.opd_valid & w_ready;
    assign w_rem_next = r_rem - {{(LEN_W-1){1'b0}}, w_xfer};

    // The first two ACC cycles seed each lane with zero; afterwards each lane feeds back
    // its own result, which arrives exactly two cycles after it was issued.
    always_comb begin
        w_alua = LNS_ZERO;
        w_alub = LNS_ZERO;
        w_aluc = LNS_ZERO;
        case (r_state)
            ST_ACC: begin
                if (r_acc_cnt == 2'd2) w_alua = bus.alur2;
                if (w_xfer) begin
                    w_alub = bus.opd_b;
                    w_aluc = bus.opd_c;
                end
            end
            ST_DRAIN: w_alua = bus.alur2;
            ST_MERGE: begin
                w_alua = bus.alur2;
                w_alub = r_hold;
                w_aluc = LNS_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_acc_cnt <= '0;
            r_hold    <= LNS_ZERO;
            r_result  <= LNS_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_rem     <= bus.len;
                        r_acc_cnt <= '0;
                        if (bus.len == '0) begin
                            r_result <= LNS_ZERO;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    r_rem <= w_rem_next;
                    if (r_acc_cnt != 2'd2) r_acc_cnt <= r_acc_cnt + 2'd1;
                    if ((w_rem_next == '0) && (r_acc_cnt != 2'd0)) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    r_hold  <= bus.alur2;
                    r_state <= ST_MERGE;
                end
                ST_MERGE: r_state <= ST_WAIT0;
                ST_WAIT0: r_state <= ST_WAIT1;
                ST_WAIT1: begin
                    r_result <= bus.alur2;
                    r_state  <= ST_DONE;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LNS_DOT_STALL_CNT_EN
    logic [15:0] r_stall;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_stall <= '0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_stall <= '0;
        end else if (w_ready && !bus.opd_valid && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall;
`endif

    assign bus.opd_ready = w_ready;
    assign bus.alua0     = w_alua;
    assign bus.alub0     = w_alub;
    assign bus.aluc0     = w_aluc;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.result    = r_result;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_lns_dot_seq.sv
// Randomized self-checking bench for lns_dot_seq with an exact stand-in lnspipe and a dot-product model.
module tb_lns_dot_seq;
    import lns_pkg::*;

    localparam int LEN_W = 8;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;

    lns_dot_seq_if #(.LEN_W(LEN_W)) bus ();

    lns_dot_seq #(.LEN_W(LEN_W)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 sysclk = ~sysclk;

    // ---------------- stand-in lnspipe: exact modular arithmetic on decoded codes
    function automatic logic [15:0] dec(input logic [15:0] x);
        case (x)
            16'h4000: dec = 16'h0000;
            16'h0000: dec = 16'h0001;
            16'h0001: dec = 16'h4000;
            default:  dec = x;
        endcase
    endfunction

    function automatic logic [15:0] enc(input logic [15:0] v);
        case (v)
            16'h0000: enc = 16'h4000;
            16'h0001: enc = 16'h0000;
            16'h4000: enc = 16'h0001;
            default:  enc = v;
        endcase
    endfunction

    logic [15:0] pipe_s1 = 16'h4000;
    logic [15:0] pipe_s2 = 16'h4000;

    always @(posedge sysclk) begin
        pipe_s1 <= enc(dec(bus.alua0) + dec(bus.alub0) * dec(bus.aluc0));
        pipe_s2 <= pipe_s1;
    end

    assign bus.alur2 = pipe_s2;

    // ---------------- scoreboard and reference model
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] op_b[64];
    logic [15:0] op_c[64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_dot(input int n);
        logic [15:0] acc = 16'h0000;
        for (int i = 0; i < n; i++) acc += dec(op_b[i]) * dec(op_c[i]);
        return enc(acc);
    endfunction

    function automatic logic [15:0] rand_code();
        case ($urandom_range(0, 5))
            0:       return 16'h4000;
            1:       return 16'h0000;
            2:       return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    // ---------------- driver: one full dot product, checking per-cycle and at done
    task automatic run_dot(input int n, input int valid_pct, input logic [31:0] stall_mask,
                           input bit restart, output logic [15:0] res);
        int xfers   = 0;
        int bub     = 0;
        int k       = 0;
        int acc_len;
        bit seen    = 1'b0;
        bit st;
        res = '0;
        @(negedge sysclk);
        check("idle_before_start", bus.busy, 0);
        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        if (n == 0) exp_q.push_back(LNS_ZERO);
        while (!seen && k < 400) begin
            @(negedge sysclk);
            k++;
            bus.start = restart && (k == 2);
            bus.len   = LEN_W'($urandom_range(0, 255));
            if (bus.done) begin
                seen = 1'b1;
                acc_len = ((n + bub) > 2) ? (n + bub) : 2;
                check("done_cycle", k, (n == 0) ? 1 : acc_len + 5);
                check("ready_at_done", bus.opd_ready, 0);
                check("sb_count", exp_q.size(), 1);
                if (exp_q.size() != 0) check("result", bus.result, exp_q.pop_front());
`ifdef LNS_DOT_STALL_CNT_EN
                check("stall_cnt", bus.stall_cnt, bub);
`endif
                res           = bus.result;
                bus.start     = restart;
                bus.opd_valid = 1'b0;
            end else begin
                check("busy_run", bus.busy, 1);
                check("ready_run", bus.opd_ready, (xfers < n) ? 1 : 0);
                if (xfers < n) begin
                    st = (k < 32) ? stall_mask[k[4:0]] : 1'b0;
                    bus.opd_valid = !st && ($urandom_range(0, 99) < valid_pct);
                    bus.opd_b     = op_b[xfers];
                    bus.opd_c     = op_c[xfers];
                    if (bus.opd_valid) begin
                        xfers++;
                        if (xfers == n) exp_q.push_back(model_dot(n));
                    end else begin
                        bub++;
                    end
                end else begin
                    bus.opd_valid = 1'($urandom_range(0, 1));
                    bus.opd_b     = 16'($urandom());
                    bus.opd_c     = 16'($urandom());
                end
            end
        end
        if (!seen) check("done_timeout", k, 0);
        @(negedge sysclk);
        bus.start = 1'b0;
        check("done_pulse", bus.done, 0);
        check("idle_after_done", bus.busy, 0);
        repeat (2) begin
            @(negedge sysclk);
            check("no_extra_done", bus.done, 0);
        end
    endtask

    // ---------------- main sequence
    initial begin
        logic [15:0] r;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.opd_valid = 1'b0;
        bus.opd_b     = '0;
        bus.opd_c     = '0;
        reset         = 1'b1;
        repeat (3) @(negedge sysclk);
        check("rst_busy",   bus.busy, 0);
        check("rst_done",   bus.done, 0);
        check("rst_result", bus.result, 16'h4000);
        check("rst_ready",  bus.opd_ready, 0);
        check("rst_alua0",  bus.alua0, 16'h4000);
        check("rst_alub0",  bus.alub0, 16'h4000);
        check("rst_aluc0",  bus.aluc0, 16'h4000);
        check("rst_state",  bus.dbg_state, ST_IDLE);
`ifdef LNS_DOT_STALL_CNT_EN
        check("rst_stall_cnt", bus.stall_cnt, 0);
`endif
        reset = 1'b0;

        // empty dot product
        run_dot(0, 100, 32'h0, 1'b0, r);
        check("len0_result", r, 16'h4000);

        // 1.0*1.0 + 1.0*1.0
        for (int i = 0; i < 2; i++) begin op_b[i] = 16'h0000; op_c[i] = 16'h0000; end
        run_dot(2, 100, 32'h0, 1'b0, r);
        check("len2_ones", r, 16'h0002);

        // all-zero matrix row
        for (int i = 0; i < 5; i++) begin op_b[i] = 16'h4000; op_c[i] = 16'($urandom()); end
        run_dot(5, 100, 32'h0, 1'b0, r);
        check("zero_row", r, 16'h4000);

        // same terms without and with three bubbles (cycles 2, 3, 5)
        for (int i = 0; i < 4; i++) begin op_b[i] = rand_code(); op_c[i] = rand_code(); end
        run_dot(4, 100, 32'h0, 1'b0, r);
        run_dot(4, 100, 32'h0000_002C, 1'b0, r);
        check("stall_same_result", r, model_dot(4));

        // reset during the third ACC cycle, then a single 1.0*1.0 term
        @(negedge sysclk);
        bus.start     = 1'b1;
        bus.len       = LEN_W'(4);
        bus.opd_valid = 1'b1;
        bus.opd_b     = 16'($urandom());
        bus.opd_c     = 16'($urandom());
        @(negedge sysclk);
        bus.start = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        reset         = 1'b0;
        bus.opd_valid = 1'b0;
        check("midrst_busy",   bus.busy, 0);
        check("midrst_done",   bus.done, 0);
        check("midrst_result", bus.result, 16'h4000);
        check("midrst_ready",  bus.opd_ready, 0);
        check("midrst_alua0",  bus.alua0, 16'h4000);
        op_b[0] = 16'h0000;
        op_c[0] = 16'h0000;
        run_dot(1, 100, 32'h0, 1'b0, r);
        check("post_reset_len1", r, 16'h0000);

        // start pulses while busy must be ignored
        for (int i = 0; i < 6; i++) begin op_b[i] = rand_code(); op_c[i] = rand_code(); end
        run_dot(6, 70, 32'h0, 1'b1, r);

        // randomized lengths, operands and valid density
        for (int t = 0; t < 25; t++) begin
            int n;
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) begin op_b[i] = rand_code(); op_c[i] = rand_code(); end
            run_dot(n, $urandom_range(40, 100), 32'h0, 1'($urandom_range(0, 1)), r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lns_dot_seq.md
LNS_DOT_SEQ -- requirements
Module: lns_dot_seq

Interface
REQ-001 Parameter: LEN_W, default 8, width of the term-count input len.
REQ-002 sysclk  in  1  sole clock, all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  begin a dot product; sampled only in IDLE.
REQ-005 len  in  LEN_W  number of terms; sampled together with start.
REQ-006 opd_valid  in  1  operand pair available.
REQ-007 opd_ready  out  1  sequencer accepts an operand pair; transfer = opd_valid & opd_ready.
REQ-008 opd_b  in  16  LNS matrix element.
REQ-009 opd_c  in  16  LNS vector element.
REQ-010 alua0, alub0, aluc0  out  16 each  operands to the downstream lnspipe stage, which computes alua0 + alub0*aluc0.
REQ-011 alur2  in  16  lnspipe result, valid 2 cycles after issue.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse when result is updated.
REQ-014 result  out  16  final LNS dot product, held until the next done.

Function
REQ-015 Encoding: LNS_ZERO = 16'h4000 (value 0); LNS_ONE = 16'h0000 (value 1.0).
REQ-016 States: IDLE, ACC, DRAIN, MERGE, WAIT0, WAIT1, DONE.
REQ-017 IDLE: all three ALU outputs = LNS_ZERO; opd_ready = 0.
REQ-018 IDLE with start = 1 and len = 0: go to DONE with result = LNS_ZERO.
REQ-019 IDLE with start = 1 and len != 0: go to ACC; the remaining-term counter loads len.
REQ-020 A start pulse while busy is ignored.
REQ-021 ACC issues a term every cycle, with two interleaved partial sums (lanes) selected by cycle parity.
REQ-022 ACC opd_ready = (remaining != 0).
REQ-023 On a transfer: alub0 = opd_b, aluc0 = opd_c, and remaining decrements.
REQ-024 With no transfer (bubble): alub0 = LNS_ZERO, aluc0 = LNS_ZERO.
REQ-025 alua0 = LNS_ZERO in the first two ACC cycles (prime); otherwise alua0 = alur2, combinationally.
REQ-026 ACC exits to DRAIN when remaining = 0 and at least 2 ACC cycles have elapsed; so len = 1 spends 2 ACC cycles.
REQ-027 DRAIN: issue alua0 = alur2, alub0 = aluc0 = LNS_ZERO; capture alur2 into hold register H (final value of one lane).
REQ-028 MERGE: issue alua0 = alur2 (other lane final), alub0 = H, aluc0 = LNS_ONE.
REQ-029 WAIT0: ALU outputs = LNS_ZERO.
REQ-030 WAIT1: ALU outputs = LNS_ZERO; result <= alur2 at the end of the cycle.
REQ-031 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-032 Latency, no stalls: start accepted at edge 0 -> done high in cycle max(len,2)+5.
REQ-033 Each bubble adds one cycle of latency.
REQ-034 The block performs no arithmetic itself; all sums come from lnspipe. Relies on x + 0*y = x and 1.0*H = H being exact in LNSAddSub.

Reset
REQ-035 reset forces IDLE from any state, including mid-ACC; in-flight terms are discarded.
REQ-036 Reset values: busy = 0, done = 0, result = LNS_ZERO, opd_ready = 0, H = LNS_ZERO, counters = 0.
REQ-037 Reset values: alua0, alub0, aluc0 = LNS_ZERO.

Configuration
REQ-038 Macro LNS_DOT_STALL_CNT_EN defined: adds output stall_cnt [15:0], cleared on an accepted start, incremented on each ACC bubble while remaining != 0, saturating at 16'hFFFF.
REQ-039 Macro LNS_DOT_STALL_CNT_EN undefined: port and logic absent; all other behaviour identical.

Structure
REQ-040 Shared package lns_pkg holds LNS_ZERO, LNS_ONE and the state enumeration type.
REQ-041 No sub-module: lnspipe is instantiated beside this block at the core level, with alur2 fed back.

Verification
REQ-042 start, len = 0 -> done in cycle 1, result = 16'h4000, opd_ready never high.
REQ-043 len = 2, operands (0x0000,0x0000) twice, valid always -> done in cycle 7, result = model(1.0+1.0).
REQ-044 len = 5, all opd_b = 16'h4000 -> result = 16'h4000 regardless of opd_c.
REQ-045 len = 4, opd_valid low in 3 ACC cycles -> done delayed by 3 cycles, result equals the no-stall run; stall_cnt = 3 when enabled.
REQ-046 reset asserted in the 3rd ACC cycle, then a new start with len = 1, operands (0x0000,0x0000) -> done in cycle 7, result = 16'h0000.
REQ-047 start pulsed again while busy -> ignored; a single done pulse occurs.
